// File: rtl/simon_core.sv
// simon_core: parametrised SIMON encrypt/decrypt engine with a stored round-key file,
// driven by the newX/ldX/doneX four-phase handshakes.
module simon_core #(
   parameter int N = 32,
   parameter int M = 3,
   parameter int T = 42,
   parameter int Co = 6
) (
   input  logic           clk,
   input  logic           R,
   input  logic           newKey,
   input  logic [M*N-1:0] key,
   output logic           ldKey,
   output logic           doneKey,
   input  logic           newData,
   input  logic           enc_dec,
   input  logic [2*N-1:0] plain,
   output logic           ldData,
   output logic           doneData,
   input  logic           readData,
   output logic [2*N-1:0] cipher
);
   localparam int RW = $clog2(T);
   localparam int ZI = Co < 5 ? Co : (M == 4 ? 3 : 2);
   localparam int K3 = M == 4 ? 3 : 1;
   localparam logic [4:0][61:0] ZT = {
      62'b11010001111001101011011000100000010111000011001010010011101111,
      62'b11011011101011000110010111100000010010001010011100110100001111,
      62'b10101111011100000011010010011000101000010001111110010110110011,
      62'b10001110111110010011000010110101000111011111001001100001011010,
      62'b11111010001001010110000111001101111101000100101011000011100110};
   localparam logic [61:0] ZS = ZT[3'(ZI)];
   typedef enum logic [1:0] {KIDLE, KLD, KEXP, KRDY} kst_t;
   typedef enum logic [1:0] {DIDLE, DRUN, DDONE, DACK} dst_t;
   kst_t kst, kst_n;
   dst_t dst, dst_n;
   logic [N-1:0] rk [T];
   logic [N-1:0] x, y, xn, yn, t0, t1, kn, rkr;
   logic [RW-1:0] i, r;
   logic [5:0] zc;
   logic mode, kcap, dcap, klast, dlast;
   function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
      return (v << s) | (v >> (N - s));
   endfunction
   function automatic logic [N-1:0] f(input logic [N-1:0] v);
      return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
   endfunction
   always_comb begin
      kcap = (kst == KIDLE || kst == KRDY) && newKey && !ldKey && dst == DIDLE;
      dcap = dst == DIDLE && newData && !ldData && kst == KRDY && !kcap;
      klast = i == RW'(T - 1);
      dlast = r == RW'(T - 1);
      // KLD is the settle cycle between the last round-key write and doneKey
      kst_n = kcap ? KEXP : kst == KEXP ? (klast ? KLD : KEXP) : kst == KLD ? KRDY : kst;
      dst_n = dcap ? DRUN : dst == DRUN ? (dlast ? DDONE : DRUN) :
              dst == DDONE ? (doneData && readData ? DACK : DDONE) :
              dst == DACK ? (readData ? DACK : DIDLE) : dst;
      doneKey = kst == KRDY;
      cipher = {x, y};
      t0 = rol(rk[i - RW'(1)], N - 3) ^ (M == 4 ? rk[i - RW'(K3)] : '0);
      t1 = t0 ^ rol(t0, N - 1);
      kn = ~rk[i - RW'(M)] ^ t1 ^ N'(ZS[6'd61 - zc]) ^ N'(3);
      rkr = rk[mode ? r : RW'(T - 1) - r];
      xn = mode ? y ^ f(x) ^ rkr : y;
      yn = mode ? x : x ^ f(y) ^ rkr;
   end
   always_ff @(posedge clk) begin
      if (R) begin
         kst <= KIDLE;
         dst <= DIDLE;
      end else begin
         kst <= kst_n;
         dst <= dst_n;
      end
   end
   always_ff @(posedge clk) begin
      if (R) begin
         {ldKey, ldData, doneData, mode, x, y, i, r, zc} <= '0;
      end else begin
         ldKey <= kcap | (ldKey & newKey);
         ldData <= dcap | (ldData & newData);
         doneData <= dst == DDONE && !(doneData && readData);
         if (kcap) begin
            for (int j = 0; j < M; j++) rk[RW'(j)] <= key[j*N +: N];
            i <= RW'(M);
            zc <= '0;
         end else if (kst == KEXP) begin
            rk[i] <= kn;
            i <= i + RW'(1);
            zc <= zc == 6'd61 ? '0 : zc + 6'd1;
         end
         if (dcap) begin
            x <= plain[2*N-1:N];
            y <= plain[N-1:0];
            mode <= enc_dec;
            r <= '0;
         end else if (dst == DRUN) begin
            x <= xn;
            y <= yn;
            r <= dlast ? '0 : r + RW'(1);
         end
      end
   end
endmodule

// File: tb/tb_simon_core.sv
// tb_simon_core: directed SIMON vectors on three variants, checked against a block-level model.
module tb_simon_core;
   localparam int TN [3] = '{32, 16, 64};
   localparam int TM [3] = '{3, 4, 2};
   localparam int TT [3] = '{42, 32, 68};
   localparam int TZ [3] = '{2, 0, 2};
   localparam logic [61:0] ZT [5] = '{
      62'b11111010001001010110000111001101111101000100101011000011100110,
      62'b10001110111110010011000010110101000111011111001001100001011010,
      62'b10101111011100000011010010011000101000010001111110010110110011,
      62'b11011011101011000110010111100000010010001010011100110100001111,
      62'b11010001111001101011011000100000010111000011001010010011101111};
   logic clk = 0, R = 1, enc = 1, rd = 0;
   logic [127:0] kb = '0, pb = '0;
   logic [2:0] nk = '0, nd = '0, lk, dk, ldd, ddn, pk = '0, pdk = '0, pld = '0, pdd = '0;
   logic [63:0] c0;
   logic [31:0] c1;
   logic [127:0] c2;
   logic [127:0] cv [3];
   logic [127:0] exp_c [3];
   logic [127:0] kk [3];
   int kt [3], dt [3], krise [3];
   int cyc = 0, checks = 0, errors = 0;
   simon_core u0 (.clk(clk), .R(R), .newKey(nk[0]), .key(kb[95:0]), .ldKey(lk[0]), .doneKey(dk[0]),
      .newData(nd[0]), .enc_dec(enc), .plain(pb[63:0]), .ldData(ldd[0]), .doneData(ddn[0]),
      .readData(rd), .cipher(c0));
   simon_core #(.N(16), .M(4), .T(32), .Co(0)) u1 (.clk(clk), .R(R), .newKey(nk[1]), .key(kb[63:0]),
      .ldKey(lk[1]), .doneKey(dk[1]), .newData(nd[1]), .enc_dec(enc), .plain(pb[31:0]),
      .ldData(ldd[1]), .doneData(ddn[1]), .readData(rd), .cipher(c1));
   simon_core #(.N(64), .M(2), .T(68), .Co(2)) u2 (.clk(clk), .R(R), .newKey(nk[2]), .key(kb),
      .ldKey(lk[2]), .doneKey(dk[2]), .newData(nd[2]), .enc_dec(enc), .plain(pb),
      .ldData(ldd[2]), .doneData(ddn[2]), .readData(rd), .cipher(c2));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always_comb begin
      cv[0] = {64'b0, c0};
      cv[1] = {96'b0, c1};
      cv[2] = c2;
   end
   task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask
   function automatic logic [63:0] rl(input logic [63:0] v, input int s, input int n);
      logic [63:0] m = n == 64 ? '1 : (64'd1 << n) - 64'd1;
      return ((v << s) | (v >> (n - s))) & m;
   endfunction
   function automatic logic [63:0] ff(input logic [63:0] v, input int n);
      return (rl(v, 1, n) & rl(v, 8, n)) ^ rl(v, 2, n);
   endfunction
   function automatic logic [127:0] model(input int s, input logic [127:0] k, input logic [127:0] p, input logic e);
      int n = TN[s];
      int m = TM[s];
      int t = TT[s];
      logic [63:0] msk = n == 64 ? '1 : (64'd1 << n) - 64'd1;
      logic [61:0] z = ZT[TZ[s]];
      logic [63:0] w [72];
      logic [63:0] x, y, tmp;
      for (int j = 0; j < m; j++) w[j] = 64'(k >> (j * n)) & msk;
      for (int j = m; j < t; j++) begin
         tmp = rl(w[j-1], n - 3, n);
         if (m == 4) tmp ^= w[j-3];
         tmp ^= rl(tmp, n - 1, n);
         w[j] = (msk ^ 64'd3) ^ 64'(z[61 - (j - m) % 62]) ^ w[j-m] ^ tmp;
      end
      x = 64'(p >> n) & msk;
      y = 64'(p) & msk;
      for (int j = 0; j < t; j++) begin
         if (e) begin
            tmp = x;
            x = y ^ ff(x, n) ^ w[j];
            y = tmp;
         end else begin
            tmp = y;
            y = x ^ ff(y, n) ^ w[t-1-j];
            x = tmp;
         end
      end
      return (128'(x) << n) | 128'(y);
   endfunction
   function automatic logic sigv(input int s, input int w);
      return w == 0 ? lk[s] : w == 1 ? dk[s] : w == 2 ? ldd[s] : ddn[s];
   endfunction
   task automatic wait_sig(input int s, input int w, input logic v, input string nm);
      int n = 0;
      while (sigv(s, w) !== v && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 128'(sigv(s, w)), 128'(v));
   endtask
   task automatic do_key(input int s, input logic [127:0] k);
      kb = k;
      kk[s] = k;
      nk[s] = 1;
      wait_sig(s, 0, 1, "ldKey rise");
      nk[s] = 0;
      wait_sig(s, 1, 1, "doneKey rise");
      wait_sig(s, 0, 0, "ldKey fall");
   endtask
   task automatic do_blk(input int s, input logic [127:0] p, input logic e, input logic [127:0] lit, input bit pulse);
      int k0 = krise[s];
      pb = p;
      enc = e;
      exp_c[s] = model(s, kk[s], p, e);
      nd[s] = 1;
      wait_sig(s, 2, 1, "ldData rise");
      nd[s] = 0;
      if (pulse) begin
         @(negedge clk);
         nk[s] = 1;
         repeat (2) @(negedge clk);
         nk[s] = 0;
      end
      wait_sig(s, 3, 1, "doneData rise");
      chk("cipher vector", cv[s], lit);
      chk("doneKey kept", 128'(dk[s]), 128'(1));
      chk("no key reload", 128'(krise[s]), 128'(k0));
      rd = 1;
      wait_sig(s, 3, 0, "doneData fall");
      rd = 0;
      repeat (2) @(negedge clk);
   endtask
   always @(negedge clk) begin
      for (int s = 0; s < 3; s++) begin
         if (lk[s] && !pk[s]) begin
            kt[s] = cyc;
            krise[s]++;
         end
         if (dk[s] && !pdk[s]) chk("doneKey latency", 128'(cyc - kt[s]), 128'(TT[s] - TM[s] + 1));
         if (ldd[s] && !pld[s]) dt[s] = cyc;
         if (ddn[s] && !pdd[s]) chk("doneData latency", 128'(cyc - dt[s]), 128'(TT[s] + 1));
         if (ddn[s]) chk("cipher vs model", cv[s], exp_c[s]);
      end
      pk = lk;
      pdk = dk;
      pld = ldd;
      pdd = ddn;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         chk("reset flags", 128'({lk[s], dk[s], ldd[s], ddn[s]}), 128'(0));
         chk("reset cipher", cv[s], 128'(0));
      end
      R = 0;
      chk("model 64/96", model(0, 128'h131211100b0a090803020100, 128'h6f7220676e696c63, 1), 128'h5ca2e27f111a8fc8);
      chk("model 32/64", model(1, 128'h1918111009080100, 128'h65656877, 1), 128'hc69be9bb);
      chk("model 32/64 dec", model(1, 128'h1918111009080100, 128'hc69be9bb, 0), 128'h65656877);
      pb = 128'h6f7220676e696c63;
      enc = 1;
      nd[0] = 1;
      repeat (4) @(negedge clk);
      chk("ldData before key", 128'(ldd[0]), 128'(0));
      do_key(0, 128'h131211100b0a090803020100);
      chk("ldData held during expansion", 128'(ldd[0]), 128'(0));
      do_blk(0, 128'h6f7220676e696c63, 1, 128'h5ca2e27f111a8fc8, 1);
      do_blk(0, 128'h5ca2e27f111a8fc8, 0, 128'h6f7220676e696c63, 0);
      do_key(1, 128'h1918111009080100);
      do_blk(1, 128'h65656877, 1, 128'hc69be9bb, 0);
      do_blk(1, 128'hc69be9bb, 0, 128'h65656877, 0);
      do_key(2, 128'h0f0e0d0c0b0a09080706050403020100);
      do_blk(2, 128'h63736564207372656c6c657661727420, 1, 128'h49681b1e1e54fe3f65aa832af84e0bbc, 0);
      do_blk(2, 128'h49681b1e1e54fe3f65aa832af84e0bbc, 0, 128'h63736564207372656c6c657661727420, 0);
      pb = 128'h6f7220676e696c63;
      enc = 1;
      nd[0] = 1;
      wait_sig(0, 2, 1, "ldData rise pre-abort");
      nd[0] = 0;
      repeat (19) @(negedge clk);
      R = 1;
      @(negedge clk);
      R = 0;
      chk("abort flags", 128'({lk[0], dk[0], ldd[0], ddn[0]}), 128'(0));
      chk("abort cipher", cv[0], 128'(0));
      nd[0] = 1;
      repeat (50) @(negedge clk);
      chk("ldData without key", 128'(ldd[0]), 128'(0));
      chk("doneData without key", 128'(ddn[0]), 128'(0));
      nd[0] = 0;
      repeat (2) @(negedge clk);
      do_key(0, 128'h131211100b0a090803020100);
      do_blk(0, 128'h6f7220676e696c63, 1, 128'h5ca2e27f111a8fc8, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/simon_core.md
Name: simon_core

Overview:
- Parametrised SIMON block-cipher engine covering every standard SIMON variant (32/64 through 128/256) from one RTL source.
- Supports encryption and decryption.
- Successor to the fixed 64/96 core. Adds a stored round-key file, so decryption runs with reversed keys and a loaded key is reused across any number of blocks.
- Sits behind the system bus adapter and uses the same newX/ldX/doneX four-phase handshakes.

Parameters:
- N, 32, word size in bits (16, 24, 32, 48, 64).
- M, 3, key words (2, 3, 4).
- T, 42, rounds (32, 36, 42, 44, 52, 54, 68, 69, 72).
- Co, 6, key-schedule constant index. Co 0..4 selects z0..z4. Co>=5 selects z2 for M=2 or M=3 and z3 for M=4.

Ports:
- clk, in, 1, single clock, rising edge.
- R, in, 1, reset, synchronous, active-high.
- newKey, in, 1, request to load key.
- key, in, M*N, key words, key[N-1:0]=k0.
- ldKey, out, 1, key captured; held until newKey low.
- doneKey, out, 1, round keys valid.
- newData, in, 1, request to process block.
- enc_dec, in, 1, 1=encrypt, 0=decrypt; sampled with plain.
- plain, in, 2N, input block, x=upper N, y=lower N.
- ldData, out, 1, block captured; held until newData low.
- doneData, out, 1, result valid on cipher.
- readData, in, 1, consumer acknowledge.
- cipher, out, 2N, result block {x,y}.

Behaviour:
- One clock; reset is synchronous and active-high.
- While R=1 at a clk edge: all outputs 0, both FSMs to IDLE, key marked invalid. Round-key file contents are don't-care.
- R asserted mid-operation aborts that operation.
- Key FSM states: KIDLE, KLD, KEXP, KRDY.
- KIDLE/KRDY + newKey=1 + data FSM in DIDLE:
  - k0..k(M-1) are written.
  - ldKey=1 and doneKey=0 from the next cycle.
  - State goes to KEXP.
- KEXP writes one round key per cycle:
  - tmp = ROR3(k[i-1]).
  - If M=4: tmp ^= k[i-3].
  - tmp ^= ROR1(tmp).
  - k[i] = ~k[i-M] ^ tmp ^ z[(i-M) mod 62] ^ 3.
- doneKey rises the cycle after k(T-1) is written, i.e. T-M+1 cycles after capture. It stays high until the next key capture.
- ldKey falls the cycle after newKey is sampled low, independent of KEXP progress.
- Data FSM states: DIDLE, DRUN, DDONE, DACK.
- DIDLE + newData=1 + doneKey=1 + no key capture this edge:
  - x, y, mode and round counter r=0 are loaded.
  - ldData=1 from the next cycle; ldData falls the cycle after newData is sampled low.
- DRUN performs one round per cycle, with f(v) = (ROL1 v & ROL8 v) ^ ROL2 v:
  - Encrypt: x' = y ^ f(x) ^ k[r], y' = x.
  - Decrypt: x' = y, y' = x ^ f(y) ^ k[T-1-r].
- After T rounds (r wraps at T-1) the FSM goes to DDONE:
  - doneData=1, exactly T+1 cycles after capture.
  - cipher holds the result, stable until the next capture.
- DDONE + readData=1: doneData drops next cycle and the FSM goes to DACK.
- DACK: waits for readData=0, then returns to DIDLE.
- newData high during DDONE/DACK is held off and accepted only in DIDLE.
- newData before any key (doneKey=0): not accepted, ldData stays 0.
- newKey and newData both high in idle: key has priority; data is accepted after doneKey rises.
- newKey while data FSM not in DIDLE: ignored until DIDLE. The round-key file is never modified mid-block.
- All rotations are modulo N; round counter width is clog2(T).

Test Plan:
- Default 64/96, key 131211100B0A090803020100, encrypt plain 6F7220676E696C63 -> cipher 5CA2E27F111A8FC8, doneData T+1=43 cycles after ldData rises.
- Same core, read acknowledged, plain=cipher, enc_dec=0, key unchanged -> cipher 6F7220676E696C63; no key reload (ldKey stays 0).
- N=16, M=4, T=32, Co=0, key 1918111009080100, encrypt 65656877 -> c69be9bb; decrypt returns 65656877.
- N=64, M=2, T=68, Co=2, key 0f0e0d0c0b0a09080706050403020100, encrypt 63736564207372656c6c657661727420 -> 49681b1e1e54fe3f65aa832af84e0bbc.
- newData asserted before newKey, then key loaded:
  - ldData stays 0 until doneKey=1.
  - Block then processed correctly.
  - newKey pulsed during DRUN changes nothing until DIDLE.
- R=1 for one cycle mid-DRUN at round 20 -> all outputs 0 next cycle, doneKey=0; newData alone then ignored until key reloaded.
